cio_responder: RTL and testbench

- Console-side responder for the processor's character I/O handshake (Cout / CinReq / CioAcq).
- Serves output requests by converting the BCD data cell to a binary byte and pushing it onto a byte-stream transmitter (UART TX).
- Serves input requests by popping a received byte from a small RX FIFO, converting it to BCD and returning it on DataCin.
- Sits outside the processor core, between its console port and the UART.

---
 rtl/cio_responder.sv | 164 ++++++++++++++++
 tb/tb_cio_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cio_responder.sv
// Console-side responder for the processor character I/O handshake: BCD cell to UART byte on
// Cout, RX FIFO byte to BCD on CinReq, one CioAcq pulse per request level.
module cio_responder #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned DIGIT_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cout,
  input  logic                          i_cin_req,
  output logic                          o_cio_acq,
  input  logic [DIGITS*DIGIT_WIDTH-1:0] i_data,
  output logic [DIGITS*DIGIT_WIDTH-1:0] o_data_cin,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_rx_overflow,
  output logic                          o_busy
);

  localparam int unsigned DW = DIGITS * DIGIT_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StTxSend,
    StCinWait,
    StConv,
    StAck,
    StRelease
  } state_e;

  state_e r_state, w_state_next;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rx_overflow;
  logic          w_empty, w_full, w_push, w_pop;
  logic [7:0]    w_head;

  logic [7:0]    r_tx_data;
  logic [7:0]    w_tx_byte;
  logic [7:0]    r_bin;
  logic [11:0]   r_bcd;
  logic [2:0]    r_cnt;
  logic [11:0]   w_bcd_adj, w_bcd_shift;
  logic [DW-1:0] r_data_cin;

  // RX FIFO: a push in the pop cycle is always accepted, even when full.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = (r_state == StCinWait) && !w_empty;
  assign w_push  = i_rx_valid && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rx_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (i_rx_valid && w_full && !w_pop) begin
        r_rx_overflow <= 1'b1;
      end
    end
  end

  // Horner evaluation in 8 bits gives the mod-256 result directly.
  always_comb begin
    w_tx_byte = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_tx_byte = w_tx_byte * 8'd10 + 8'(i_data[i*DIGIT_WIDTH +: DIGIT_WIDTH]);
    end
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 3; k++) begin
      if (w_bcd_adj[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = w_bcd_adj[4*k +: 4] + 4'd3;
      end
    end
    w_bcd_shift = {w_bcd_adj[10:0], r_bin[7]};
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_cout) begin
          w_state_next = StTxSend;
        end else if (i_cin_req) begin
          w_state_next = StCinWait;
        end
      end
      StTxSend:  if (i_tx_ready) w_state_next = StAck;
      StCinWait: if (!w_empty) w_state_next = StConv;
      StConv:    if (r_cnt == 3'd7) w_state_next = StAck;
      StAck:     w_state_next = StRelease;
      StRelease: if (!i_cout && !i_cin_req) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_tx_data  <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_data_cin <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_cout) begin
        r_tx_data <= w_tx_byte;
      end
      if (w_pop) begin
        r_bin <= w_head;
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (r_state == StConv) begin
        r_bcd <= w_bcd_shift;
        r_bin <= {r_bin[6:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_data_cin <= DW'(w_bcd_shift);
        end
      end
    end
  end

  assign o_tx_valid    = (r_state == StTxSend);
  assign o_tx_data     = r_tx_data;
  assign o_cio_acq     = (r_state == StAck);
  assign o_busy        = (r_state != StIdle);
  assign o_data_cin    = r_data_cin;
  assign o_rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_cio_responder.sv
// Scoreboard bench for cio_responder: expected TX bytes and acknowledges are queued by the
// stimulus and retired by an independent monitor.
module tb_cio_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cout, cin_req, cio_acq;
  logic [11:0] data, data_cin;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_overflow, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_tx[$];
  logic [11:0] exp_ack[$];
  logic [11:0] last_cin = 12'h000;

  cio_responder #(
    .DIGITS     (3),
    .DIGIT_WIDTH(4),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cout       (cout),
    .i_cin_req    (cin_req),
    .o_cio_acq    (cio_acq),
    .i_data       (data),
    .o_data_cin   (data_cin),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_overflow(rx_overflow),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: retires queued expectations whenever the DUT presents a transfer or acknowledge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (cio_acq) begin
        if (exp_ack.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else check("ack_data_cin", 32'(data_cin), 32'(exp_ack.pop_front()));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    sync();
    rx_valid = 1'b0;
  endtask

  // Output request; with stall>0 TxReady stays low until cycle stall+1.
  task automatic do_out(input logic [11:0] d, input int stall, input logic [7:0] eb,
                        input int exp_lat);
    int  n;
    bit  got;
    exp_tx.push_back(eb);
    exp_ack.push_back(last_cin);
    data     = d;
    cout     = 1'b1;
    tx_ready = (stall == 0);
    n        = 0;
    got      = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n >= 2 && n < exp_lat) begin
        check("tx_valid_held", 32'(tx_valid), 32'd1);
        check("tx_data_stable", 32'(tx_data), 32'(eb));
      end
      if (cio_acq) got = 1;
      else if (stall > 0 && n == stall) begin
        sync();
        tx_ready = 1'b1;
      end
    end
    check("out_latency", 32'(n), 32'(exp_lat));
    sync();
    sync();
    @(negedge clk);
    check("release_busy", 32'(busy), 32'd1);
    sync();
    cout = 1'b0;
    sync();
    @(negedge clk);
    check("idle_after_out", 32'(busy), 32'd0);
    sync();
  endtask

  // Input request; optionally pushes byte pb during cycle push_at of the wait.
  task automatic do_in(input logic [11:0] exp_cin, input int exp_lat, input int push_at,
                       input logic [7:0] pb);
    int n;
    bit got;
    last_cin = exp_cin;
    exp_ack.push_back(exp_cin);
    cin_req = 1'b1;
    n       = 0;
    got     = 0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (cio_acq) got = 1;
      else if (n == push_at) begin
        rx_data  = pb;
        rx_valid = 1'b1;
        sync();
        rx_valid = 1'b0;
      end
    end
    check("in_latency", 32'(n), 32'(exp_lat));
    sync();
    cin_req = 1'b0;
    sync();
    @(negedge clk);
    check("idle_after_in", 32'(busy), 32'd0);
    sync();
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_cio_acq", 32'(cio_acq), 32'd0);
    check("rst_data_cin", 32'(data_cin), 32'd0);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_tx.delete();
    exp_ack.delete();
    last_cin = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    cout     = 1'b0;
    cin_req  = 1'b0;
    data     = '0;
    tx_ready = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync();

    // Output path and backpressure
    do_out(12'h072, 0, 8'h48, 3);
    do_out(12'h255, 5, 8'hFF, 7);
    do_out(12'h300, 0, 8'h2C, 3);

    // Input path, then a request that waits on an empty FIFO
    push_rx(8'h7B);
    do_in(12'h123, 11, 0, 8'h00);
    do_in(12'h000, 30, 20, 8'h00);

    // Overflow: fifth byte dropped, then a later byte proves 0x45 was lost
    push_rx(8'h41);
    push_rx(8'h42);
    push_rx(8'h43);
    push_rx(8'h44);
    check("no_overflow_at_full", 32'(rx_overflow), 32'd0);
    push_rx(8'h45);
    check("overflow_set", 32'(rx_overflow), 32'd1);
    do_in(12'h065, 11, 0, 8'h00);
    do_in(12'h066, 11, 0, 8'h00);
    do_in(12'h067, 11, 0, 8'h00);
    do_in(12'h068, 11, 0, 8'h00);
    do_in(12'h042, 25, 15, 8'h2A);
    check("overflow_sticky", 32'(rx_overflow), 32'd1);

    // Push into a full FIFO in the pop cycle is kept without overflow
    do_reset();
    push_rx(8'h01);
    push_rx(8'h02);
    push_rx(8'h03);
    push_rx(8'h04);
    do_in(12'h001, 11, 2, 8'h05);
    check("no_overflow_on_pop_push", 32'(rx_overflow), 32'd0);
    do_in(12'h002, 11, 0, 8'h00);
    do_in(12'h003, 11, 0, 8'h00);
    do_in(12'h004, 11, 0, 8'h00);
    do_in(12'h005, 11, 0, 8'h00);

    // Simultaneous requests: output first, input served after both drop
    push_rx(8'h0A);
    exp_tx.push_back(8'h41);
    exp_ack.push_back(last_cin);
    data    = 12'h065;
    cout    = 1'b1;
    cin_req = 1'b1;
    begin
      int n;
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        n++;
        if (cio_acq) break;
      end
      check("both_latency", 32'(n), 32'd3);
    end
    repeat (3) sync();
    @(negedge clk);
    check("both_release_busy", 32'(busy), 32'd1);
    sync();
    cout    = 1'b0;
    cin_req = 1'b0;
    sync();
    do_in(12'h010, 11, 0, 8'h00);

    // Reset during CONV with a full FIFO and overflow set
    push_rx(8'h11);
    push_rx(8'h12);
    push_rx(8'h13);
    push_rx(8'h14);
    push_rx(8'h15);
    check("pre_reset_overflow", 32'(rx_overflow), 32'd1);
    cin_req = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cin_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync();
    do_in(12'h009, 22, 12, 8'h09);

    // Reset during a stalled TX_SEND
    data     = 12'h123;
    cout     = 1'b1;
    tx_ready = 1'b0;
    repeat (3) sync();
    @(negedge clk);
    check("stalled_tx_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cout     = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) sync();
    check("post_reset_idle", 32'(busy), 32'd0);

    check("exp_tx_left", 32'(exp_tx.size()), 32'd0);
    check("exp_ack_left", 32'(exp_ack.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
